mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage access unit: consumer of the execute-stage pipeline register (address, store data, byte-enable size masks, ALU result, writeback controls).
- Drives a req/gnt/rvalid data-memory handshake, lane-aligns stores, extracts and extends loads, and stalls the pipeline until the access completes.
- Produces registered writeback-stage outputs.

Parameters:
- MAX_WAIT, 15: cycles spent in REQ+WAIT before a bus timeout error is declared.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  execute-stage register holds a valid instruction
- flush  in  1  squash current instruction (no architectural effect)
- exe_addr  in  32  data address
- exe_wdata  in  32  store data (rt value)
- exe_result  in  32  ALU/link result for non-load instructions
- mem_read_en  in  4  load size mask: 0001 byte, 0011 half, 1111 word, 0000 none
- mem_write_en  in  4  store size mask, same encoding
- load_signed  in  1  sign-extend byte/half loads
- reg_wen_in  in  1  writeback enable
- reg_num_in  in  5  destination register
- dmem_req  out  1  memory request
- dmem_wr  out  1  1 = store
- dmem_be  out  4  byte lane enables
- dmem_addr  out  32  word-aligned address ({exe_addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word
- stall_out  out  1  hold upstream pipeline
- wb_valid  out  1  writeback slot valid
- wb_data  out  32  writeback data
- reg_wen_out  out  1  writeback enable
- reg_num_out  out  5  writeback register
- addr_err  out  1  misaligned or illegal-mask access (one-cycle pulse with wb_valid)
- bus_err  out  1  memory timeout (one-cycle pulse with wb_valid)

Behaviour:
- Reset: all outputs 0; state IDLE; wait counter 0; dmem_req deasserted immediately at the clock edge with rst=0, including mid-handshake.
- Encoding: both masks nonzero is illegal and raises addr_err.
  - Masks other than 0000/0001/0011/1111 are illegal and raise addr_err.
  - Half access with addr[0]=1 raises addr_err.
  - Word access with addr[1:0]!=0 raises addr_err.
- Definitions:
  - access = in_valid & (mem_read_en|mem_write_en != 0) & !flush
  - start = access & legal & aligned
- States: IDLE, REQ, WAIT, DONE.
- IDLE, no start: one-cycle registered pass-through.
  - wb_valid <= in_valid; wb_data <= exe_result; reg_wen_out <= reg_wen_in & in_valid & !flush & !err.
  - Misaligned/illegal: addr_err <= 1, reg_wen_out <= 0, no request.
  - stall_out = 0.
- IDLE with start: latch addr, be = size mask << addr[1:0], wdata, wr, signed, reg fields; set dmem_req=1 next cycle; go to REQ; stall_out = 1 combinationally.
- Store data replication: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
- REQ: dmem_req/dmem_* held stable until dmem_gnt.
  - On gnt: dmem_req <= 0; store goes to DONE, load goes to WAIT.
  - stall_out = 1.
- WAIT: on dmem_rvalid (may arrive the cycle after gnt at earliest), capture the extended load into wb_data and go to DONE. stall_out = 1.
- Load extraction: lane = addr[1:0]; byte from rdata[8*lane+7:8*lane]; half from rdata[16*addr[1]+15:16*addr[1]]; sign- or zero-extend per load_signed.
- DONE (exactly one cycle):
  - wb_valid = 1 with the registered result; stall_out = 0 so upstream advances.
  - Inputs are not sampled for start in DONE (they still show the finished instruction).
  - Next state is IDLE.
  - Stores: wb_valid = 1, reg_wen_out = 0.
- Minimum latency: load 4 cycles start→DONE (gnt same cycle as REQ entry, rvalid next); store 3.
- Timeout: counter increments each REQ/WAIT cycle and clears on entering REQ. At MAX_WAIT: dmem_req <= 0, bus_err = 1 in DONE, reg_wen_out = 0.
- Flush mid-operation:
  - REQ is not abandoned; the handshake completes.
  - A latched flushed flag forces reg_wen_out = 0 in DONE.
  - Flush does not cancel an already granted store.
- gnt outside REQ and rvalid outside WAIT are ignored.

Test Plan:
- Word load: addr 0x100, mask 1111, gnt in REQ cycle 1, rvalid 2 cycles later with 0xDEADBEEF → dmem_be = 1111, stall high 3 cycles, DONE wb_data = 0xDEADBEEF, reg_wen_out = 1.
- Signed byte load: addr 0x103, mask 0001, rdata 0x80AABBCC → be = 1000, wb_data = 0xFFFFFF80; same with load_signed = 0 → 0x00000080.
- Half store: addr 0x0202, wdata 0x12345678, mask 0011 → dmem_wr = 1, be = 1100, dmem_wdata = 0x56785678, addr 0x200, DONE with reg_wen_out = 0.
- Misaligned word: addr 0x101, mask 1111 → no dmem_req, next cycle addr_err = 1, wb_valid = 1, reg_wen_out = 0, stall_out never asserted.
- Timeout: gnt held low, MAX_WAIT = 15 → dmem_req drops after 15 REQ cycles, bus_err = 1 in DONE, reg_wen_out = 0.
- Flush in WAIT and reset in REQ: flush raised in WAIT → completes on rvalid with reg_wen_out = 0; rst = 0 during REQ → next cycle dmem_req = 0, all outputs 0, state IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage access unit. Takes the execute-stage pipeline register, runs a
// req/gnt/rvalid handshake to data memory for loads and stores, and produces
// registered writeback-stage outputs. The upstream pipeline is stalled for the
// whole handshake.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   in_valid, flush   execute-stage instruction valid / squash
//   exe_addr          data address
//   exe_wdata         store data
//   exe_result        ALU/link result for non-load instructions
//   mem_read_en       load size mask  (0001 byte, 0011 half, 1111 word)
//   mem_write_en      store size mask (same encoding)
//   load_signed       sign-extend byte/half loads
//   reg_wen_in        writeback enable
//   reg_num_in        destination register
//   dmem_req/wr/be/addr/wdata   memory request (held stable until dmem_gnt)
//   dmem_gnt          request accepted
//   dmem_rvalid/rdata load data return
//   stall_out         hold upstream pipeline
//   wb_valid, wb_data, reg_wen_out, reg_num_out   writeback-stage outputs
//   addr_err          misaligned / illegal-mask access (pulse with wb_valid)
//   bus_err           memory timeout (pulse with wb_valid)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        flush,
    input  logic [31:0] exe_addr,
    input  logic [31:0] exe_wdata,
    input  logic [31:0] exe_result,
    input  logic [3:0]  mem_read_en,
    input  logic [3:0]  mem_write_en,
    input  logic        load_signed,
    input  logic        reg_wen_in,
    input  logic [4:0]  reg_num_in,
    output logic        dmem_req,
    output logic        dmem_wr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        reg_wen_out,
    output logic [4:0]  reg_num_out,
    output logic        addr_err,
    output logic        bus_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [1:0]         lat_lane;
    logic [3:0]         lat_rmask;
    logic               lat_signed;
    logic               lat_reg_wen;
    logic               flushed;

    logic [3:0]         size_mask;
    logic               mask_ok;
    logic               aligned;
    logic               access;
    logic               start;
    logic               bad;
    logic               timeout;
    logic [31:0]        store_data;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        load_data;

    // Access decode for the instruction currently in the execute register.
    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        size_mask = mem_read_en | mem_write_en;
        mask_ok   = ((mem_read_en == 4'b0000) || (mem_write_en == 4'b0000)) &&
                    (size_mask inside {4'b0000, 4'b0001, 4'b0011, 4'b1111});
        aligned   = 1'b1;
        case (size_mask)
            4'b0011: aligned = (exe_addr[0] == 1'b0);
            4'b1111: aligned = (exe_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        access = in_valid && (size_mask != 4'b0000) && !flush;
        bad    = access && !(mask_ok && aligned);
        // Gated by rst so stall_out is 0 while reset is held.
        start  = rst && (state == S_IDLE) && access && mask_ok && aligned;
    end

    // Store data replicated across every lane the access may land in.
    always_comb begin
        case (mem_write_en)
            4'b0001: store_data = {4{exe_wdata[7:0]}};
            4'b0011: store_data = {2{exe_wdata[15:0]}};
            default: store_data = exe_wdata;
        endcase
    end

    // Load extraction from the returned word using the latched lane.
    always_comb begin
        byte_sel = dmem_rdata[{lat_lane, 3'b000} +: 8];
        half_sel = dmem_rdata[{lat_lane[1], 4'b0000} +: 16];
        case (lat_rmask)
            4'b0001: load_data = {{24{lat_signed & byte_sel[7]}}, byte_sel};
            4'b0011: load_data = {{16{lat_signed & half_sel[15]}}, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    // Counter spans REQ and WAIT together; cleared when REQ is entered.
    assign timeout = (wait_cnt == CNT_W'(MAX_WAIT - 1));

    always_comb begin
        stall_out = start || (state == S_REQ) || (state == S_WAIT);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            lat_lane    <= '0;
            lat_rmask   <= '0;
            lat_signed  <= 1'b0;
            lat_reg_wen <= 1'b0;
            flushed     <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_wr     <= 1'b0;
            dmem_be     <= '0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            reg_wen_out <= 1'b0;
            reg_num_out <= '0;
            addr_err    <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_REQ;
                        wait_cnt    <= '0;
                        dmem_req    <= 1'b1;
                        dmem_wr     <= (mem_write_en != 4'b0000);
                        dmem_be     <= size_mask << exe_addr[1:0];
                        dmem_addr   <= {exe_addr[31:2], 2'b00};
                        dmem_wdata  <= store_data;
                        lat_lane    <= exe_addr[1:0];
                        lat_rmask   <= mem_read_en;
                        lat_signed  <= load_signed;
                        lat_reg_wen <= reg_wen_in;
                        flushed     <= 1'b0;
                        reg_num_out <= reg_num_in;
                        wb_valid    <= 1'b0;
                        reg_wen_out <= 1'b0;
                        addr_err    <= 1'b0;
                        bus_err     <= 1'b0;
                    end else begin
                        // Single-cycle registered pass-through.
                        wb_valid    <= in_valid;
                        wb_data     <= exe_result;
                        reg_wen_out <= reg_wen_in & in_valid & !flush & !bad;
                        reg_num_out <= reg_num_in;
                        addr_err    <= bad;
                        bus_err     <= 1'b0;
                    end
                end

                S_REQ: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (flush) flushed <= 1'b1;
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (dmem_wr) begin
                            // A granted store always completes without a
                            // register write, flushed or not.
                            state       <= S_DONE;
                            wb_valid    <= 1'b1;
                            wb_data     <= '0;
                            reg_wen_out <= 1'b0;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else if (timeout) begin
                        dmem_req    <= 1'b0;
                        state       <= S_DONE;
                        wb_valid    <= 1'b1;
                        wb_data     <= '0;
                        reg_wen_out <= 1'b0;
                        bus_err     <= 1'b1;
                    end
                end

                S_WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (flush) flushed <= 1'b1;
                    if (dmem_rvalid) begin
                        state       <= S_DONE;
                        wb_valid    <= 1'b1;
                        wb_data     <= load_data;
                        reg_wen_out <= lat_reg_wen & !flushed & !flush;
                    end else if (timeout) begin
                        state       <= S_DONE;
                        wb_valid    <= 1'b1;
                        wb_data     <= '0;
                        reg_wen_out <= 1'b0;
                        bus_err     <= 1'b1;
                    end
                end

                S_DONE: begin
                    // Result was visible for exactly this cycle; inputs still
                    // hold the finished instruction and are not sampled.
                    state       <= S_IDLE;
                    wb_valid    <= 1'b0;
                    reg_wen_out <= 1'b0;
                    addr_err    <= 1'b0;
                    bus_err     <= 1'b0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit: a table of single-cycle
// pass-through / error vectors, then hand-written handshake sequences for
// loads, stores, flush during WAIT, bus timeout and reset during REQ.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic [31:0] exe_addr;
    logic [31:0] exe_wdata;
    logic [31:0] exe_result;
    logic [3:0]  mem_read_en;
    logic [3:0]  mem_write_en;
    logic        load_signed;
    logic        reg_wen_in;
    logic [4:0]  reg_num_in;
    logic        dmem_req;
    logic        dmem_wr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_out;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        reg_wen_out;
    logic [4:0]  reg_num_out;
    logic        addr_err;
    logic        bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(.MAX_WAIT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .flush        (flush),
        .exe_addr     (exe_addr),
        .exe_wdata    (exe_wdata),
        .exe_result   (exe_result),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .load_signed  (load_signed),
        .reg_wen_in   (reg_wen_in),
        .reg_num_in   (reg_num_in),
        .dmem_req     (dmem_req),
        .dmem_wr      (dmem_wr),
        .dmem_be      (dmem_be),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .stall_out    (stall_out),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .reg_wen_out  (reg_wen_out),
        .reg_num_out  (reg_num_out),
        .addr_err     (addr_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        flush        = 1'b0;
        exe_addr     = '0;
        exe_wdata    = '0;
        exe_result   = '0;
        mem_read_en  = '0;
        mem_write_en = '0;
        load_signed  = 1'b0;
        reg_wen_in   = 1'b0;
        reg_num_in   = '0;
    endtask

    // One full memory access: start cycle, REQ with immediate gnt, optional
    // WAIT cycles, DONE, and the following IDLE cycle.
    task automatic do_access(input string name, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] rd,
                             input logic [3:0] wr, input logic sgn,
                             input logic [3:0] e_be, input logic [31:0] e_wdata,
                             input logic [31:0] rdata, input logic [31:0] e_data,
                             input logic e_wen, input logic flush_wait);
        logic is_store;
        is_store     = (wr != 4'b0000);
        in_valid     = 1'b1;
        exe_addr     = addr;
        exe_wdata    = wdata;
        exe_result   = 32'h5A5A5A5A;
        mem_read_en  = rd;
        mem_write_en = wr;
        load_signed  = sgn;
        reg_wen_in   = 1'b1;
        reg_num_in   = 5'd9;
        #1 check({name, " start stall"}, stall_out, 1);
        tick();
        // REQ: rvalid here must be ignored.
        check({name, " req"}, dmem_req, 1);
        check({name, " be"}, dmem_be, e_be);
        check({name, " addr"}, dmem_addr, {addr[31:2], 2'b00});
        check({name, " wr"}, dmem_wr, is_store);
        if (is_store) check({name, " wdata"}, dmem_wdata, e_wdata);
        check({name, " req stall"}, stall_out, 1);
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hBAD0BAD0;
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (!is_store) begin
            check({name, " wait req"}, dmem_req, 0);
            check({name, " wait stall"}, stall_out, 1);
            check({name, " wait wbv"}, wb_valid, 0);
            if (flush_wait) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
                check({name, " wait2 stall"}, stall_out, 1);
            end
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
            tick();
            dmem_rvalid = 1'b0;
        end
        // DONE
        check({name, " done wbv"}, wb_valid, 1);
        if (!is_store) check({name, " done data"}, wb_data, e_data);
        check({name, " done wen"}, reg_wen_out, e_wen);
        check({name, " done num"}, reg_num_out, 9);
        check({name, " done aerr"}, addr_err, 0);
        check({name, " done berr"}, bus_err, 0);
        check({name, " done stall"}, stall_out, 0);
        tick();
        // DONE must not have re-sampled the still-valid inputs.
        check({name, " idle req"}, dmem_req, 0);
        check({name, " idle wbv"}, wb_valid, 0);
        idle_inputs();
        tick();
    endtask

    typedef struct {
        logic        v;
        logic        fl;
        logic [31:0] addr;
        logic [31:0] res;
        logic [3:0]  rd;
        logic [3:0]  wr;
        logic        wen;
        logic [4:0]  num;
        logic        e_wbv;
        logic        e_wen;
        logic        e_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        //             v     fl    addr          res           rd       wr       wen   num    wbv   wen   err
        vecs[0] = '{1'b1, 1'b0, 32'h00000000, 32'h11111111, 4'b0000, 4'b0000, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'h00000000, 32'h22222222, 4'b0000, 4'b0000, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h00000000, 32'h33333333, 4'b0000, 4'b0000, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h00000101, 32'h44444444, 4'b1111, 4'b0000, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'h00000103, 32'h55555555, 4'b0011, 4'b0000, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'h00000000, 32'h66666666, 4'b0001, 4'b0001, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'h00000000, 32'h77777777, 4'b0111, 4'b0000, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 32'h00000000, 32'h88888888, 4'b0000, 4'b0010, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 32'h00000101, 32'h99999999, 4'b1111, 4'b0000, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 32'h00000102, 32'hAAAAAAAA, 4'b0000, 4'b1111, 1'b0, 5'd14, 1'b1, 1'b0, 1'b1};

        rst         = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        idle_inputs();
        tick();
        tick();
        check("reset req", dmem_req, 0);
        check("reset wbv", wb_valid, 0);
        check("reset wen", reg_wen_out, 0);
        check("reset stall", stall_out, 0);
        rst = 1'b1;
        tick();

        // Pass-through and illegal/misaligned accesses: no request, no stall.
        for (int i = 0; i < 10; i++) begin
            in_valid     = vecs[i].v;
            flush        = vecs[i].fl;
            exe_addr     = vecs[i].addr;
            exe_result   = vecs[i].res;
            mem_read_en  = vecs[i].rd;
            mem_write_en = vecs[i].wr;
            reg_wen_in   = vecs[i].wen;
            reg_num_in   = vecs[i].num;
            #1 check($sformatf("vec%0d stall", i), stall_out, 0);
            tick();
            check($sformatf("vec%0d req", i), dmem_req, 0);
            check($sformatf("vec%0d wbv", i), wb_valid, vecs[i].e_wbv);
            check($sformatf("vec%0d data", i), wb_data, vecs[i].res);
            check($sformatf("vec%0d wen", i), reg_wen_out, vecs[i].e_wen);
            check($sformatf("vec%0d num", i), reg_num_out, vecs[i].num);
            check($sformatf("vec%0d aerr", i), addr_err, vecs[i].e_err);
            check($sformatf("vec%0d stall2", i), stall_out, 0);
        end
        idle_inputs();
        tick();

        //        name          addr          wdata         rd       wr       sgn   be       e_wdata       rdata         e_data        wen   flush
        do_access("ld_word",   32'h00000100, 32'h0,        4'b1111, 4'b0000, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0);
        do_access("ld_sb",     32'h00000103, 32'h0,        4'b0001, 4'b0000, 1'b1, 4'b1000, 32'h0,        32'h80AABBCC, 32'hFFFFFF80, 1'b1, 1'b0);
        do_access("ld_ub",     32'h00000103, 32'h0,        4'b0001, 4'b0000, 1'b0, 4'b1000, 32'h0,        32'h80AABBCC, 32'h00000080, 1'b1, 1'b0);
        do_access("ld_sh_hi",  32'h00000102, 32'h0,        4'b0011, 4'b0000, 1'b1, 4'b1100, 32'h0,        32'h80AABBCC, 32'hFFFF80AA, 1'b1, 1'b0);
        do_access("ld_uh_lo",  32'h00000100, 32'h0,        4'b0011, 4'b0000, 1'b0, 4'b0011, 32'h0,        32'h1234F00D, 32'h0000F00D, 1'b1, 1'b0);
        do_access("ld_sb_l1",  32'h00000101, 32'h0,        4'b0001, 4'b0000, 1'b1, 4'b0010, 32'h0,        32'h11227F33, 32'h0000007F, 1'b1, 1'b0);
        do_access("st_half",   32'h00000202, 32'h12345678, 4'b0000, 4'b0011, 1'b0, 4'b1100, 32'h56785678, 32'h0,        32'h0,        1'b0, 1'b0);
        do_access("st_byte",   32'h00000301, 32'hAABBCCDD, 4'b0000, 4'b0001, 1'b0, 4'b0010, 32'hDDDDDDDD, 32'h0,        32'h0,        1'b0, 1'b0);
        do_access("st_word",   32'h00000400, 32'hCAFEBABE, 4'b0000, 4'b1111, 1'b0, 4'b1111, 32'hCAFEBABE, 32'h0,        32'h0,        1'b0, 1'b0);
        do_access("ld_flush",  32'h00000104, 32'h0,        4'b1111, 4'b0000, 1'b0, 4'b1111, 32'h0,        32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b1);

        // Timeout: gnt never arrives; request held for exactly 15 REQ cycles.
        in_valid    = 1'b1;
        exe_addr    = 32'h00000500;
        mem_read_en = 4'b1111;
        reg_wen_in  = 1'b1;
        reg_num_in  = 5'd3;
        tick();
        for (int i = 0; i < 15; i++) begin
            check($sformatf("tmo req c%0d", i), dmem_req, 1);
            check($sformatf("tmo stall c%0d", i), stall_out, 1);
            tick();
        end
        check("tmo done req", dmem_req, 0);
        check("tmo done berr", bus_err, 1);
        check("tmo done wbv", wb_valid, 1);
        check("tmo done wen", reg_wen_out, 0);
        check("tmo done stall", stall_out, 0);
        idle_inputs();
        dmem_gnt = 1'b1;   // late grant outside REQ is ignored
        tick();
        dmem_gnt = 1'b0;
        check("tmo after berr", bus_err, 0);
        check("tmo after req", dmem_req, 0);
        check("tmo after wbv", wb_valid, 0);

        // Reset while in REQ.
        in_valid   = 1'b1;
        exe_result = 32'hCAFEF00D;
        reg_wen_in = 1'b1;
        reg_num_in = 5'd4;
        tick();
        check("pre-rst data", wb_data, 32'hCAFEF00D);
        exe_addr     = 32'h00000600;
        exe_wdata    = 32'h01020304;
        mem_write_en = 4'b1111;
        reg_num_in   = 5'd17;
        tick();
        check("pre-rst req", dmem_req, 1);
        rst = 1'b0;
        tick();
        check("rst req", dmem_req, 0);
        check("rst wr", dmem_wr, 0);
        check("rst be", dmem_be, 0);
        check("rst addr", dmem_addr, 0);
        check("rst wdata", dmem_wdata, 0);
        check("rst wbv", wb_valid, 0);
        check("rst data", wb_data, 0);
        check("rst wen", reg_wen_out, 0);
        check("rst num", reg_num_out, 0);
        check("rst stall", stall_out, 0);
        rst = 1'b1;
        idle_inputs();
        in_valid   = 1'b1;
        exe_result = 32'h00000077;
        reg_wen_in = 1'b1;
        reg_num_in = 5'd2;
        #1 check("post-rst stall", stall_out, 0);
        tick();
        check("post-rst wbv", wb_valid, 1);
        check("post-rst data", wb_data, 32'h00000077);
        check("post-rst wen", reg_wen_out, 1);
        check("post-rst req", dmem_req, 0);
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
